// File: rtl/mipi_tx_pkg.sv
// MIPI TX line scheduler: shared package.
// Holds the scheduler FSM state type and the default geometry constants.
package mipi_tx_pkg;

  localparam int DEF_LINE_W   = 12;
  localparam int DEF_WORD_W   = 11;
  localparam int DEF_VACTIVE  = 2160;
  localparam int DEF_WORDS    = 810;
  localparam int DEF_RST_LINE = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LINE,
    S_READ,
    S_STALL,
    S_LINE_END,
    S_FRAME_END
  } state_t;

endpackage

// File: rtl/mipi_tx_rstf_gen.sv
// MIPI TX FIFO reset generator: counts Hsyncs since Vsync and holds rstf
// low while the count equals the selected line.
// Ports: CLK_tx/RSTn clock and async reset; i_vsync/i_hsync sync pulses;
//        i_rst_line line index (already reflecting a same-cycle Vsync latch);
//        o_rstf registered active-low FIFO reset.
module mipi_tx_rstf_gen
  import mipi_tx_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W
) (
  input  logic              CLK_tx,
  input  logic              RSTn,
  input  logic              i_vsync,
  input  logic              i_hsync,
  input  logic [LINE_W-1:0] i_rst_line,
  output logic              o_rstf
);

  logic [LINE_W-1:0] r_hs_cnt;
  logic [LINE_W-1:0] w_hs_nxt;
  logic              r_rstf;

  always_comb begin
    w_hs_nxt = r_hs_cnt;
    if (i_vsync) begin
      w_hs_nxt = '0;
    end else if (i_hsync && (r_hs_cnt != '1)) begin
      w_hs_nxt = r_hs_cnt + LINE_W'(1);
    end
  end

  // rstf is derived from the next count so it lines up with hs_cnt.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      r_hs_cnt <= '0;
      r_rstf   <= 1'b0;
    end else begin
      r_hs_cnt <= w_hs_nxt;
      r_rstf   <= (w_hs_nxt != i_rst_line);
    end
  end

  assign o_rstf = r_rstf;

endmodule

// File: rtl/mipi_tx_line_sched.sv
// MIPI TX line scheduler: issues cfg_words FIFO reads per Hsync line for
// cfg_vactive lines per frame, with optional almost-empty stalls.
// Ports: CLK_tx/RSTn clock and async reset; Vsync/Hsync/frame_start timing;
//        cfg_* frame config (latched on Vsync); fifo_* channel flags;
//        fifo_readen/rstf FIFO controls; line_done/frame_done pulses;
//        underflow/line_overrun sticky error flags.
module mipi_tx_line_sched
  import mipi_tx_pkg::*;
#(
  parameter int LINE_W = DEF_LINE_W,
  parameter int WORD_W = DEF_WORD_W,
  parameter int NUM_CH = 1
) (
  input  logic              CLK_tx,
  input  logic              RSTn,
  input  logic              Vsync,
  input  logic              Hsync,
  input  logic              frame_start,
  input  logic [LINE_W-1:0] cfg_vactive,
  input  logic [WORD_W-1:0] cfg_words,
  input  logic [LINE_W-1:0] cfg_rst_line,
  input  logic              cfg_wait_ae,
  input  logic [NUM_CH-1:0] fifo_almostempty,
  input  logic [NUM_CH-1:0] fifo_empty,
  output logic              fifo_readen,
  output logic              rstf,
  output logic              line_done,
  output logic              frame_done,
  output logic              underflow,
  output logic              line_overrun
);

  localparam logic [LINE_W-1:0] L_ONE = LINE_W'(1);
  localparam logic [WORD_W-1:0] W_ONE = WORD_W'(1);

  state_t r_state;
  state_t w_nxt;
  state_t w_first;

  logic [LINE_W-1:0] r_vactive;
  logic [WORD_W-1:0] r_words;
  logic [LINE_W-1:0] r_rst_line;
  logic              r_wait_ae;

  logic [LINE_W-1:0] r_line_cnt;
  logic [LINE_W-1:0] w_line_nxt;
  logic [WORD_W-1:0] r_word_cnt;
  logic [WORD_W-1:0] w_word_nxt;

  logic r_readen;
  logic r_line_done;
  logic r_frame_done;
  logic r_underflow;
  logic r_overrun;

  logic              w_start;
  logic              w_stall;
  logic              w_last_word;
  logic              w_ovr_set;
  logic [LINE_W-1:0] w_rst_line_nxt;

  assign w_start     = Hsync && frame_start &&
                       (r_line_cnt < r_vactive);
  assign w_stall     = r_wait_ae && (|fifo_almostempty);
  assign w_last_word = (r_word_cnt == (r_words - W_ONE));
  // A zero-word line skips straight to its end-of-line pulse.
  assign w_first     = (r_words == '0) ? S_LINE_END : S_READ;

  always_comb begin
    w_nxt      = r_state;
    w_line_nxt = r_line_cnt;
    w_word_nxt = r_word_cnt;
    w_ovr_set  = 1'b0;
    if (Vsync) begin
      w_nxt      = S_WAIT_LINE;
      w_line_nxt = '0;
      w_word_nxt = '0;
    end else begin
      unique case (r_state)
        S_IDLE: w_nxt = S_IDLE;
        S_WAIT_LINE: begin
          if (w_start) begin
            w_nxt      = w_first;
            w_line_nxt = r_line_cnt + L_ONE;
            w_word_nxt = '0;
          end
        end
        S_READ, S_STALL: begin
          if (Hsync) begin
            // Early Hsync abandons the line and may start the next one.
            w_ovr_set = 1'b1;
            w_nxt     = S_WAIT_LINE;
            if (w_start) begin
              w_nxt      = w_first;
              w_line_nxt = r_line_cnt + L_ONE;
              w_word_nxt = '0;
            end
          end else begin
            if (r_state == S_READ) begin
              w_word_nxt = r_word_cnt + W_ONE;
            end
            if ((r_state == S_READ) && w_last_word) begin
              w_nxt = S_LINE_END;
            end else begin
              w_nxt = w_stall ? S_STALL : S_READ;
            end
          end
        end
        S_LINE_END: begin
          w_nxt = (r_line_cnt == r_vactive) ?
                  S_FRAME_END : S_WAIT_LINE;
        end
        S_FRAME_END: w_nxt = S_IDLE;
        default: w_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      r_vactive  <= LINE_W'(DEF_VACTIVE);
      r_words    <= WORD_W'(DEF_WORDS);
      r_rst_line <= LINE_W'(DEF_RST_LINE);
      r_wait_ae  <= 1'b0;
    end else if (Vsync) begin
      r_vactive  <= cfg_vactive;
      r_words    <= cfg_words;
      r_rst_line <= cfg_rst_line;
      r_wait_ae  <= cfg_wait_ae;
    end
  end

  // Outputs are registered from the next state so each one is high
  // exactly while the FSM sits in the matching state.
  always_ff @(posedge CLK_tx or negedge RSTn) begin
    if (!RSTn) begin
      r_state      <= S_IDLE;
      r_line_cnt   <= '0;
      r_word_cnt   <= '0;
      r_readen     <= 1'b0;
      r_line_done  <= 1'b0;
      r_frame_done <= 1'b0;
      r_underflow  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_nxt;
      r_line_cnt   <= w_line_nxt;
      r_word_cnt   <= w_word_nxt;
      r_readen     <= (w_nxt == S_READ);
      r_line_done  <= (w_nxt == S_LINE_END);
      r_frame_done <= (w_nxt == S_FRAME_END);
      if (Vsync) begin
        r_underflow <= 1'b0;
        r_overrun   <= 1'b0;
      end else begin
        if (r_readen && (|fifo_empty)) begin
          r_underflow <= 1'b1;
        end
        if (w_ovr_set) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign w_rst_line_nxt = Vsync ? cfg_rst_line : r_rst_line;

  mipi_tx_rstf_gen #(
    .LINE_W(LINE_W)
  ) u_rstf_gen (
    .CLK_tx    (CLK_tx),
    .RSTn      (RSTn),
    .i_vsync   (Vsync),
    .i_hsync   (Hsync),
    .i_rst_line(w_rst_line_nxt),
    .o_rstf    (rstf)
  );

  assign fifo_readen  = r_readen;
  assign line_done    = r_line_done;
  assign frame_done   = r_frame_done;
  assign underflow    = r_underflow;
  assign line_overrun = r_overrun;

endmodule

// File: tb/tb_mipi_tx_line_sched.sv
// Self-checking bench for mipi_tx_line_sched.
// Lines are predicted per Hsync from the read/stall/frame rules.
module tb_mipi_tx_line_sched;

  localparam int LW = 12;
  localparam int WW = 11;
  localparam int NC = 2;

  logic          CLK_tx = 1'b0;
  logic          RSTn;
  logic          Vsync;
  logic          Hsync;
  logic          frame_start;
  logic [LW-1:0] cfg_vactive;
  logic [WW-1:0] cfg_words;
  logic [LW-1:0] cfg_rst_line;
  logic          cfg_wait_ae;
  logic [NC-1:0] fifo_almostempty;
  logic [NC-1:0] fifo_empty;
  logic          fifo_readen;
  logic          rstf;
  logic          line_done;
  logic          frame_done;
  logic          underflow;
  logic          line_overrun;

  int total = 0;
  int bad   = 0;

  // Reference state: latched config and frame progress.
  int m_vact, m_words, m_rst, m_lines, m_hs;
  bit m_wait, m_can, m_uf, m_ovr, m_pend;
  bit ae_pat[64];
  bit em_pat[64];

  always #5 CLK_tx = ~CLK_tx;

  mipi_tx_line_sched #(
    .LINE_W(LW),
    .WORD_W(WW),
    .NUM_CH(NC)
  ) dut (
    .CLK_tx          (CLK_tx),
    .RSTn            (RSTn),
    .Vsync           (Vsync),
    .Hsync           (Hsync),
    .frame_start     (frame_start),
    .cfg_vactive     (cfg_vactive),
    .cfg_words       (cfg_words),
    .cfg_rst_line    (cfg_rst_line),
    .cfg_wait_ae     (cfg_wait_ae),
    .fifo_almostempty(fifo_almostempty),
    .fifo_empty      (fifo_empty),
    .fifo_readen     (fifo_readen),
    .rstf            (rstf),
    .line_done       (line_done),
    .frame_done      (frame_done),
    .underflow       (underflow),
    .line_overrun    (line_overrun)
  );

  task automatic tick();
    @(posedge CLK_tx);
    #1;
  endtask

  function automatic logic [NC-1:0] pick(input bit on);
    logic [NC-1:0] v;
    v = '0;
    if (on) v[$urandom_range(NC-1, 0)] = 1'b1;
    return v;
  endfunction

  task automatic clr_pats();
    for (int i = 0; i < 64; i++) begin
      ae_pat[i] = 1'b0;
      em_pat[i] = 1'b0;
    end
  endtask

  task automatic gen_pats(input int p_ae, input int p_em);
    for (int i = 0; i < 64; i++) begin
      ae_pat[i] = (i < 20) && ($urandom_range(99, 0) < p_ae);
      em_pat[i] = ($urandom_range(99, 0) < p_em);
    end
  endtask

  task automatic set_cfg(input int va, input int wd,
                         input int rl, input bit wa);
    cfg_vactive  = LW'(va);
    cfg_words    = WW'(wd);
    cfg_rst_line = LW'(rl);
    cfg_wait_ae  = wa;
  endtask

  task automatic model_reset();
    m_vact  = 2160;
    m_words = 810;
    m_rst   = 6;
    m_wait  = 1'b0;
    m_lines = 0;
    m_hs    = 0;
    m_can   = 1'b0;
    m_uf    = 1'b0;
    m_ovr   = 1'b0;
    m_pend  = 1'b0;
  endtask

  task automatic do_vsync(input bit with_hs);
    logic exp_rstf;
    Vsync = 1'b1;
    Hsync = with_hs;
    fifo_almostempty = '0;
    fifo_empty = '0;
    tick();
    Vsync = 1'b0;
    Hsync = 1'b0;
    m_vact  = int'(cfg_vactive);
    m_words = int'(cfg_words);
    m_rst   = int'(cfg_rst_line);
    m_wait  = cfg_wait_ae;
    m_lines = 0;
    m_hs    = 0;
    m_can   = 1'b1;
    m_uf    = 1'b0;
    m_ovr   = 1'b0;
    m_pend  = 1'b0;
    exp_rstf = (m_hs != m_rst);
    total++;
    if (fifo_readen !== 1'b0) begin
      bad++;
      $display("FAIL vsync_readen got=%b exp=0", fifo_readen);
    end
    total++;
    if (underflow !== 1'b0 || line_overrun !== 1'b0) begin
      bad++;
      $display("FAIL vsync_clear uf=%b ovr=%b exp=0 0",
               underflow, line_overrun);
    end
    total++;
    if (rstf !== exp_rstf) begin
      bad++;
      $display("FAIL vsync_rstf got=%b exp=%b", rstf, exp_rstf);
    end
  endtask

  // One Hsync followed by gap cycles. gap_req > 0 fixes the gap,
  // 0 picks a gap that lets the line finish, -1 forces an early Hsync.
  task automatic do_line(input int gap_req);
    logic [63:0] e_rd, e_ld, e_fd, a_rd, a_ld, a_fd, gm;
    int le, cnt, pos, k, gap;
    bit starts, last;
    logic exp_rstf;
    m_ovr = m_ovr | m_pend;
    m_pend = 1'b0;
    if (m_hs < 4095) m_hs++;
    starts = m_can && frame_start && (m_lines < m_vact);
    e_rd = '0; e_ld = '0; e_fd = '0;
    le = 0; last = 1'b0;
    if (starts) begin
      if (m_words > 0) begin
        e_rd[0] = 1'b1;
        cnt = 1; pos = 0; k = 0;
        while (cnt < m_words) begin
          if (!(m_wait && ae_pat[k])) begin
            pos = k + 1;
            e_rd[pos] = 1'b1;
            cnt++;
          end
          k++;
        end
        le = pos + 1;
      end
      m_lines++;
      last = (m_lines == m_vact);
    end
    if (gap_req > 0) gap = gap_req;
    else if (gap_req < 0 && starts && le >= 2)
      gap = $urandom_range(le - 1, 1);
    else gap = le + 3 + $urandom_range(2, 0);
    if (starts) begin
      if (le >= gap) begin
        m_pend = 1'b1;
        m_can = 1'b1;
      end else begin
        e_ld[le] = 1'b1;
        if (last) begin
          e_fd[le + 1] = 1'b1;
          m_can = 1'b0;
        end
      end
    end
    gm = (64'd1 << gap) - 64'd1;
    e_rd &= gm; e_ld &= gm; e_fd &= gm;
    exp_rstf = (m_hs != m_rst);
    Hsync = 1'b1;
    tick();
    Hsync = 1'b0;
    total++;
    if (line_overrun !== m_ovr) begin
      bad++;
      $display("FAIL line_overrun got=%b exp=%b hs=%0d",
               line_overrun, m_ovr, m_hs);
    end
    total++;
    if (rstf !== exp_rstf) begin
      bad++;
      $display("FAIL rstf_start got=%b exp=%b hs=%0d",
               rstf, exp_rstf, m_hs);
    end
    a_rd = '0; a_ld = '0; a_fd = '0;
    for (int i = 0; i < gap; i++) begin
      a_rd[i] = fifo_readen;
      a_ld[i] = line_done;
      a_fd[i] = frame_done;
      if (i == gap - 1) begin
        total++;
        if (underflow !== m_uf) begin
          bad++;
          $display("FAIL underflow got=%b exp=%b hs=%0d",
                   underflow, m_uf, m_hs);
        end
        total++;
        if (rstf !== exp_rstf) begin
          bad++;
          $display("FAIL rstf_end got=%b exp=%b hs=%0d",
                   rstf, exp_rstf, m_hs);
        end
      end
      m_uf = m_uf | (e_rd[i] && em_pat[i]);
      fifo_almostempty = pick(ae_pat[i]);
      fifo_empty = pick(em_pat[i]);
      if (i < gap - 1) tick();
    end
    total++;
    if (a_rd !== e_rd) begin
      bad++;
      $display("FAIL readen_mask got=%h exp=%h hs=%0d",
               a_rd, e_rd, m_hs);
    end
    total++;
    if (a_ld !== e_ld) begin
      bad++;
      $display("FAIL line_done_mask got=%h exp=%h hs=%0d",
               a_ld, e_ld, m_hs);
    end
    total++;
    if (a_fd !== e_fd) begin
      bad++;
      $display("FAIL frame_done_mask got=%h exp=%h hs=%0d",
               a_fd, e_fd, m_hs);
    end
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    Vsync = 1'b0; Hsync = 1'b0; frame_start = 1'b1;
    set_cfg(4, 8, 6, 1'b0);
    fifo_almostempty = '0; fifo_empty = '0;
    clr_pats();
    model_reset();
    repeat (3) tick();
    total++;
    if ({fifo_readen, rstf, line_done, frame_done,
         underflow, line_overrun} !== 6'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b exp=000000",
               fifo_readen, rstf, line_done, frame_done,
               underflow, line_overrun);
    end
    #2 RSTn = 1'b1;
    tick();
    do_line(0);
    do_line(0);
  endtask

  task automatic test_basic_frame();
    set_cfg(4, 8, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    repeat (5) do_line(0);
  endtask

  task automatic test_stall();
    set_cfg(2, 8, 6, 1'b1);
    do_vsync(1'b0);
    clr_pats();
    ae_pat[3] = 1'b1; ae_pat[4] = 1'b1; ae_pat[5] = 1'b1;
    do_line(0);
    gen_pats(30, 0);
    do_line(0);
  endtask

  task automatic test_underflow();
    set_cfg(3, 8, 6, 1'b0);
    do_vsync(1'b0);
    clr_pats();
    for (int i = 0; i < 20; i++) ae_pat[i] = 1'b1;
    for (int i = 0; i < 8; i++) em_pat[i] = 1'b1;
    do_line(0);
    clr_pats();
    do_line(0);
    do_vsync(1'b0);
  endtask

  task automatic test_overrun();
    set_cfg(4, 8, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    do_line(5);
    do_line(0);
    do_line(0);
    do_vsync(1'b0);
  endtask

  task automatic test_rstf();
    set_cfg(3, 2, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    repeat (9) do_line(0);
  endtask

  task automatic test_vsync_hsync();
    set_cfg(1, 4, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    do_line(2);
    do_vsync(1'b1);
    do_line(0);
    do_line(0);
  endtask

  task automatic test_frame_start_low();
    set_cfg(2, 5, 6, 1'b0);
    clr_pats();
    frame_start = 1'b0;
    do_vsync(1'b0);
    do_line(0);
    do_line(0);
    frame_start = 1'b1;
    do_line(0);
    do_line(0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 8; f++) begin
      set_cfg($urandom_range(4, 0), $urandom_range(12, 0),
              $urandom_range(8, 0), 1'($urandom_range(1, 0)));
      clr_pats();
      do_vsync(1'b0);
      for (int l = 0; l < m_vact + 2; l++) begin
        gen_pats(25, 10);
        do_line(($urandom_range(5, 0) == 0) ? -1 : 0);
      end
    end
  endtask

  task automatic test_reset_midline();
    set_cfg(4, 8, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    Hsync = 1'b1;
    tick();
    Hsync = 1'b0;
    tick();
    tick();
    total++;
    if (fifo_readen !== 1'b1) begin
      bad++;
      $display("FAIL midline_readen got=%b exp=1", fifo_readen);
    end
    #1 RSTn = 1'b0;
    #1;
    total++;
    if (fifo_readen !== 1'b0 || rstf !== 1'b0) begin
      bad++;
      $display("FAIL async_reset readen=%b rstf=%b exp=0 0",
               fifo_readen, rstf);
    end
    tick();
    tick();
    RSTn = 1'b1;
    model_reset();
    tick();
    repeat (3) do_line(0);
    set_cfg(2, 6, 6, 1'b0);
    clr_pats();
    do_vsync(1'b0);
    do_line(0);
    do_line(0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_stall();
    test_underflow();
    test_overrun();
    test_rstf();
    test_vsync_hsync();
    test_frame_start_low();
    test_random();
    test_reset_midline();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
